// File: rtl/axi_rd_reg_slice_pkg.sv
// Shared widths and slice state encodings for the AXI read-path register slice.
package axi_rd_reg_slice_pkg;

    localparam int AXI_ID_WIDTH    = 4;
    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int AXI_LEN_WIDTH   = 8;
    localparam int AXI_SIZE_WIDTH  = 3;
    localparam int AXI_BURST_WIDTH = 2;
    localparam int AXI_DATA_WIDTH  = 32;
    localparam int AXI_RESP_WIDTH  = 2;

    localparam int AR_PAYLOAD_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH
                                + AXI_LEN_WIDTH + AXI_SIZE_WIDTH
                                + AXI_BURST_WIDTH;
    localparam int R_PAYLOAD_W  = AXI_DATA_WIDTH + AXI_RESP_WIDTH + 1;

    // Bit 0 set means the main register holds a valid beat.
    typedef enum logic [1:0] {
        SLICE_EMPTY = 2'b00,
        SLICE_ONE   = 2'b01,
        SLICE_FULL  = 2'b11
    } slice_state_e;

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry skid buffer with registered valid, ready and payload.
module axi_skid_buf
    import axi_rd_reg_slice_pkg::*;
#(
    parameter int W  = 8,
    parameter bit EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    generate
        if (EN) begin : g_reg
            slice_state_e state_q, state_d;
            logic [W-1:0] main_q, main_d;
            logic [W-1:0] skid_q, skid_d;
            logic         in_ready_q, in_ready_d;
            logic         in_hs, out_hs;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                in_hs   = in_valid & in_ready_q;
                out_hs  = state_q[0] & out_ready;
                unique case (state_q)
                    SLICE_EMPTY: begin
                        if (in_hs) begin
                            state_d = SLICE_ONE;
                            main_d  = in_data;
                        end
                    end
                    SLICE_ONE: begin
                        if (in_hs && out_hs) begin
                            main_d = in_data;
                        end else if (in_hs) begin
                            state_d = SLICE_FULL;
                            skid_d  = in_data;
                        end else if (out_hs) begin
                            state_d = SLICE_EMPTY;
                        end
                    end
                    SLICE_FULL: begin
                        if (out_hs) begin
                            state_d = SLICE_ONE;
                            main_d  = skid_q;
                        end
                    end
                    default: state_d = SLICE_EMPTY;
                endcase
                in_ready_d = (state_d != SLICE_FULL);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q    <= SLICE_EMPTY;
                    main_q     <= '0;
                    skid_q     <= '0;
                    in_ready_q <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    main_q     <= main_d;
                    skid_q     <= skid_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = state_q[0];
            assign out_data  = main_q;
        end else begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk & rst_n;
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end
    endgenerate

endmodule

// File: rtl/axi_rd_reg_slice.sv
// AXI read-path register slice: independent AR and R skid buffers.
module axi_rd_reg_slice
    import axi_rd_reg_slice_pkg::*;
#(
    parameter bit AR_SLICE_EN = 1'b1,
    parameter bit R_SLICE_EN  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXI_ID_WIDTH-1:0]    s_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_araddr,
    input  logic [AXI_LEN_WIDTH-1:0]   s_arlen,
    input  logic [AXI_SIZE_WIDTH-1:0]  s_arsize,
    input  logic [AXI_BURST_WIDTH-1:0] s_arburst,
    input  logic                       s_arvalid,
    output logic                       s_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s_rdata,
    output logic [AXI_RESP_WIDTH-1:0]  s_rresp,
    output logic                       s_rlast,
    output logic                       s_rvalid,
    input  logic                       s_rready,
    output logic [AXI_ID_WIDTH-1:0]    m_arid,
    output logic [AXI_ADDR_WIDTH-1:0]  m_araddr,
    output logic [AXI_LEN_WIDTH-1:0]   m_arlen,
    output logic [AXI_SIZE_WIDTH-1:0]  m_arsize,
    output logic [AXI_BURST_WIDTH-1:0] m_arburst,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    input  logic [AXI_DATA_WIDTH-1:0]  m_rdata,
    input  logic [AXI_RESP_WIDTH-1:0]  m_rresp,
    input  logic                       m_rlast,
    input  logic                       m_rvalid,
    output logic                       m_rready
);

    logic [AR_PAYLOAD_W-1:0] ar_in, ar_out;
    logic [R_PAYLOAD_W-1:0]  r_in, r_out;

    assign ar_in = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst};
    assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst} = ar_out;

    assign r_in = {m_rdata, m_rresp, m_rlast};
    assign {s_rdata, s_rresp, s_rlast} = r_out;

    axi_skid_buf #(
        .W  (AR_PAYLOAD_W),
        .EN (AR_SLICE_EN)
    ) u_ar (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_arvalid),
        .in_ready  (s_arready),
        .in_data   (ar_in),
        .out_valid (m_arvalid),
        .out_ready (m_arready),
        .out_data  (ar_out)
    );

    axi_skid_buf #(
        .W  (R_PAYLOAD_W),
        .EN (R_SLICE_EN)
    ) u_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (m_rvalid),
        .in_ready  (m_rready),
        .in_data   (r_in),
        .out_valid (s_rvalid),
        .out_ready (s_rready),
        .out_data  (r_out)
    );

endmodule

// File: tb/tb_axi_rd_reg_slice.sv
// Directed bench for axi_rd_reg_slice: AR vector table plus R, reset and bypass sequences.
module tb_axi_rd_reg_slice;
    import axi_rd_reg_slice_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AXI_ID_WIDTH-1:0]    s_arid, m_arid;
    logic [AXI_ADDR_WIDTH-1:0]  s_araddr, m_araddr;
    logic [AXI_LEN_WIDTH-1:0]   s_arlen, m_arlen;
    logic [AXI_SIZE_WIDTH-1:0]  s_arsize, m_arsize;
    logic [AXI_BURST_WIDTH-1:0] s_arburst, m_arburst;
    logic                       s_arvalid, s_arready, m_arvalid, m_arready;
    logic [AXI_DATA_WIDTH-1:0]  s_rdata, m_rdata;
    logic [AXI_RESP_WIDTH-1:0]  s_rresp, m_rresp;
    logic                       s_rlast, s_rvalid, s_rready;
    logic                       m_rlast, m_rvalid, m_rready;

    logic [AXI_ID_WIDTH-1:0]    p_s_arid, p_m_arid;
    logic [AXI_ADDR_WIDTH-1:0]  p_s_araddr, p_m_araddr;
    logic [AXI_LEN_WIDTH-1:0]   p_s_arlen, p_m_arlen;
    logic [AXI_SIZE_WIDTH-1:0]  p_s_arsize, p_m_arsize;
    logic [AXI_BURST_WIDTH-1:0] p_s_arburst, p_m_arburst;
    logic                       p_s_arvalid, p_s_arready, p_m_arvalid, p_m_arready;
    logic [AXI_DATA_WIDTH-1:0]  p_s_rdata, p_m_rdata;
    logic [AXI_RESP_WIDTH-1:0]  p_s_rresp, p_m_rresp;
    logic                       p_s_rlast, p_s_rvalid, p_s_rready;
    logic                       p_m_rlast, p_m_rvalid, p_m_rready;

    axi_rd_reg_slice dut (
        .clk(clk), .rst_n(rst_n),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    axi_rd_reg_slice #(.AR_SLICE_EN(1'b0), .R_SLICE_EN(1'b0)) dut_pt (
        .clk(clk), .rst_n(rst_n),
        .s_arid(p_s_arid), .s_araddr(p_s_araddr), .s_arlen(p_s_arlen),
        .s_arsize(p_s_arsize), .s_arburst(p_s_arburst),
        .s_arvalid(p_s_arvalid), .s_arready(p_s_arready),
        .s_rdata(p_s_rdata), .s_rresp(p_s_rresp), .s_rlast(p_s_rlast),
        .s_rvalid(p_s_rvalid), .s_rready(p_s_rready),
        .m_arid(p_m_arid), .m_araddr(p_m_araddr), .m_arlen(p_m_arlen),
        .m_arsize(p_m_arsize), .m_arburst(p_m_arburst),
        .m_arvalid(p_m_arvalid), .m_arready(p_m_arready),
        .m_rdata(p_m_rdata), .m_rresp(p_m_rresp), .m_rlast(p_m_rlast),
        .m_rvalid(p_m_rvalid), .m_rready(p_m_rready)
    );

    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        mr;
        logic        ev;
        logic [31:0] ea;
        logic [7:0]  el;
        logic        er;
    } ar_vec_t;

    localparam int NV = 18;
    ar_vec_t tbl[NV];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic ar_vec_t mk(input logic v, input logic [31:0] a,
                                   input logic [7:0] l, input logic mr,
                                   input logic ev, input logic [31:0] ea,
                                   input logic [7:0] el, input logic er);
        ar_vec_t t;
        t.v = v; t.addr = a; t.len = l; t.mr = mr;
        t.ev = ev; t.ea = ea; t.el = el; t.er = er;
        return t;
    endfunction

    initial begin
        int midx;
        int sidx;
        int cyc;
        logic shs;
        logic stall;

        tbl[0]  = mk(1, 32'h100, 8'd3, 1, 1, 32'h100, 8'd3, 1);
        tbl[1]  = mk(0, 32'h0,   8'd0, 1, 0, 32'h0,   8'd0, 1);
        for (int k = 0; k < 8; k++)
            tbl[2+k] = mk(1, 32'(k*16), 8'(k), 1, 1, 32'(k*16), 8'(k), 1);
        tbl[10] = mk(0, 32'h0,   8'd0, 1, 0, 32'h0,   8'd0, 1);
        tbl[11] = mk(1, 32'h200, 8'd1, 0, 1, 32'h200, 8'd1, 1);
        tbl[12] = mk(1, 32'h210, 8'd2, 0, 1, 32'h200, 8'd1, 0);
        tbl[13] = mk(1, 32'h220, 8'd3, 0, 1, 32'h200, 8'd1, 0);
        tbl[14] = mk(1, 32'h2FF, 8'hF, 0, 1, 32'h200, 8'd1, 0);
        tbl[15] = mk(1, 32'h220, 8'd3, 1, 1, 32'h210, 8'd2, 1);
        tbl[16] = mk(1, 32'h220, 8'd3, 1, 1, 32'h220, 8'd3, 1);
        tbl[17] = mk(0, 32'h0,   8'd0, 1, 0, 32'h0,   8'd0, 1);

        s_arid = 4'd5; s_araddr = '0; s_arlen = '0;
        s_arsize = 3'd2; s_arburst = 2'd1; s_arvalid = 0;
        m_arready = 0; s_rready = 0;
        m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
        p_s_arid = 4'd7; p_s_araddr = '0; p_s_arlen = '0;
        p_s_arsize = 3'd2; p_s_arburst = 2'd1; p_s_arvalid = 0;
        p_m_arready = 0; p_s_rready = 0;
        p_m_rdata = '0; p_m_rresp = '0; p_m_rlast = 0; p_m_rvalid = 0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_s_arready", s_arready, 0);
        chk("rst_s_rvalid",  s_rvalid, 0);
        chk("rst_m_rready",  m_rready, 0);
        chk("rst_m_araddr",  m_araddr, 0);
        chk("rst_s_rdata",   s_rdata, 0);
        rst_n = 1;
        #1;
        chk("rel_s_arready_low", s_arready, 0);
        @(posedge clk); #1;
        chk("rel_s_arready", s_arready, 1);
        chk("rel_m_rready",  m_rready, 1);

        // AR vector table
        for (int i = 0; i < NV; i++) begin
            s_arvalid = tbl[i].v;
            s_araddr  = tbl[i].addr;
            s_arlen   = tbl[i].len;
            m_arready = tbl[i].mr;
            @(posedge clk); #1;
            chk($sformatf("ar%0d_mvalid", i), m_arvalid, tbl[i].ev);
            chk($sformatf("ar%0d_sready", i), s_arready, tbl[i].er);
            if (tbl[i].ev) begin
                chk($sformatf("ar%0d_addr", i), m_araddr, tbl[i].ea);
                chk($sformatf("ar%0d_len", i), m_arlen, tbl[i].el);
                chk($sformatf("ar%0d_id", i), m_arid, 4'd5);
                chk($sformatf("ar%0d_szb", i), {m_arsize, m_arburst}, 5'b01001);
            end
        end

        // R burst with toggling master ready
        midx = 0; sidx = 0; cyc = 0;
        while (midx < 4 && cyc < 40) begin
            m_rvalid = (sidx < 4);
            m_rdata  = 32'hA0 + 32'(sidx);
            m_rlast  = (sidx == 3);
            m_rresp  = (sidx == 2) ? 2'b10 : 2'b00;
            s_rready = cyc[0];
            #1;
            shs   = m_rvalid & m_rready;
            stall = s_rvalid & ~s_rready;
            if (s_rvalid && s_rready) begin
                chk($sformatf("r%0d_data", midx), s_rdata, 32'hA0 + 32'(midx));
                chk($sformatf("r%0d_last", midx), s_rlast, midx == 3);
                chk($sformatf("r%0d_resp", midx), s_rresp,
                    (midx == 2) ? 2'b10 : 2'b00);
                midx++;
            end
            @(posedge clk); #1;
            if (shs) sidx++;
            if (stall) begin
                chk("r_stall_valid", s_rvalid, 1);
                chk("r_stall_data", s_rdata, 32'hA0 + 32'(midx));
            end
            cyc++;
        end
        chk("r_beats_seen", midx, 4);
        m_rvalid = 0; s_rready = 1;
        @(posedge clk); @(posedge clk); #1;
        chk("r_drained", s_rvalid, 0);

        // Fill both channels, then reset mid-operation
        s_rready = 0; m_arready = 0;
        s_arvalid = 1; s_araddr = 32'h300; m_rvalid = 1; m_rdata = 32'hB0;
        @(posedge clk); #1;
        s_araddr = 32'h310; m_rdata = 32'hB1;
        @(posedge clk); #1;
        chk("full_s_arready", s_arready, 0);
        chk("full_m_rready",  m_rready, 0);
        s_arvalid = 0; m_rvalid = 0;
        #1;
        rst_n = 0;
        #1;
        chk("mid_rst_m_arvalid", m_arvalid, 0);
        chk("mid_rst_s_rvalid",  s_rvalid, 0);
        chk("mid_rst_s_arready", s_arready, 0);
        chk("mid_rst_m_rready",  m_rready, 0);
        @(posedge clk); #2;
        rst_n = 1;
        #1;
        chk("post_rst_ready_low", {s_arready, m_rready}, 2'b00);
        m_arready = 1; s_rready = 1;
        @(posedge clk); #1;
        chk("post_rst_ready", {s_arready, m_rready}, 2'b11);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("no_stale%0d", k), {m_arvalid, s_rvalid}, 2'b00);
            @(posedge clk); #1;
        end

        // Pass-through variant
        p_s_arvalid = 1; p_s_araddr = 32'h100; p_s_arlen = 8'd3;
        p_m_arready = 0;
        #1;
        chk("pt_m_arvalid", p_m_arvalid, 1);
        chk("pt_m_araddr",  p_m_araddr, 32'h100);
        chk("pt_m_arlen",   p_m_arlen, 8'd3);
        chk("pt_s_arready0", p_s_arready, 0);
        p_m_arready = 1;
        #1;
        chk("pt_s_arready1", p_s_arready, 1);
        p_m_rvalid = 1; p_m_rdata = 32'hC5; p_m_rlast = 1; p_s_rready = 1;
        #1;
        chk("pt_s_rvalid", p_s_rvalid, 1);
        chk("pt_s_rdata",  {p_s_rdata, p_s_rlast}, {32'hC5, 1'b1});
        chk("pt_m_rready", p_m_rready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_rd_reg_slice.md
Name: axi_rd_reg_slice

Overview:
- Read-path register slice inserted between the read master (axi_mst) and the read slave (axi_slv) to break timing paths on the AR and R channels.
- Each channel is a two-entry skid buffer. All outputs, including ready, are driven from flops.
- Sustains one transfer per cycle with no bubbles and preserves ordering.
- Transparent to protocol: payloads are never modified, dropped or reordered.

Parameters:
- AR_SLICE_EN, 1, 1 = register the AR channel; 0 = combinational pass-through.
- R_SLICE_EN, 1, 1 = register the R channel; 0 = combinational pass-through.
- Field widths come from the shared AXI width macros (AXI_ID/ADDR/LEN/SIZE/BURST/DATA/RESP_WIDTH), not from parameters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_arid/s_araddr/s_arlen/s_arsize/s_arburst  in  ID/ADDR/LEN/SIZE/BURST widths  AR payload from master
- s_arvalid  in  1  AR valid from master
- s_arready  out  1  AR ready to master
- s_rdata  out  DATA  R data to master
- s_rresp  out  RESP  R response to master
- s_rlast  out  1  R last to master
- s_rvalid  out  1  R valid to master
- s_rready  in  1  R ready from master
- m_arid/m_araddr/m_arlen/m_arsize/m_arburst  out  same widths  AR payload to slave
- m_arvalid  out  1  AR valid to slave
- m_arready  in  1  AR ready from slave
- m_rdata  in  DATA  R data from slave
- m_rresp  in  RESP  R response from slave
- m_rlast  in  1  R last from slave
- m_rvalid  in  1  R valid from slave
- m_rready  out  1  R ready to slave

Behaviour:
- Reset (asynchronous, rst_n low):
  - All valid outputs = 0; all ready outputs = 0.
  - Payload outputs = 0.
  - Skid buffers empty.
  - Ready outputs rise on the first clk edge after rst_n deasserts.
- Each slice holds a main register (drives downstream outputs) and a skid register. Handshake definitions:
  - in_hs = in_valid & in_ready (in_ready is the registered ready output).
  - out_hs = out_valid & out_ready.
- Slice states:
  - EMPTY: main and skid both invalid. in_ready = 1.
  - ONE: main valid, skid invalid. in_ready = 1.
  - FULL: main and skid both valid. in_ready = 0.
- Transitions:
  - EMPTY + in_hs -> ONE. Payload loads into main.
  - ONE + in_hs & out_hs -> ONE. Main reloads with the new payload.
  - ONE + in_hs & !out_hs -> FULL. Payload loads into skid; main holds.
  - ONE + !in_hs & out_hs -> EMPTY.
  - FULL + out_hs -> ONE. Skid moves to main. No input is accepted because in_ready = 0.
  - All other cases hold state.
- in_ready next value = 1 unless the next state is FULL.
- Latency: input accepted at edge N appears at the outputs after edge N (one cycle). Throughput is 1 per cycle when downstream ready is held high.
- Downstream valid is never deasserted and payload never changes while valid=1 and ready=0 (AXI stability).
- Upstream valid/payload changes while in_ready=0 are ignored. There is no data capture without a handshake.
- AR slice: payload = {id, addr, len, size, burst}, direction master->slave.
- R slice: payload = {data, resp, last}, direction slave->master. The rlast bit is carried unmodified; the slice does not count beats.
- The AR and R slices are fully independent. No outstanding-transaction tracking.
- Pass-through mode (*_SLICE_EN=0): outputs = inputs combinationally, ready = downstream ready; no flops.
- Reset asserted mid-burst: all buffered beats are discarded; the state returns to EMPTY asynchronously.

Decomposition:
- Shared include supplies the AXI width macros (existing) and the slice state encodings (EMPTY=2'b00, ONE=2'b01, FULL=2'b11).
- One natural sub-module: axi_skid_buf, parameterised by payload width and enable.
  - Instantiated twice: AR payload width = sum of the AR field widths; R payload width = DATA+RESP+1.
  - The top level only concatenates and splits payloads.
- axi_top is updated to route master<->slave through this slice.

Test Plan:
- Single AR, m_arready=1: s_araddr=0x100, s_arlen=3, s_arvalid for 1 cycle -> m_arvalid=1 with addr 0x100, len 3 exactly one cycle later, for 1 cycle.
- Back-to-back throughput: 8 ARs with addr 0x0,0x10..0x70 and all readies high -> 8 consecutive m_ar handshakes, no bubbles, same order.
- Backpressure on AR: m_arready=0 while 3 ARs are offered -> two are accepted (state FULL), then s_arready=0. Release m_arready -> addresses exit in order, one per cycle, then s_arready=1.
- R burst with a stalling master: 4 beats of data 0xA0..0xA3, rlast on the 4th, s_rready toggling 1/0 -> the master sees all 4 beats in order. Payload is stable during stalls and rlast appears only on 0xA3.
- Reset mid-operation: FULL on both channels, pulse rst_n low for 1 cycle -> all valids/readies become 0 immediately, readies return to 1 one edge after release, and no stale beat is emitted.
- Pass-through (AR_SLICE_EN=0, R_SLICE_EN=0): same stimulus as the single-AR test -> m_arvalid in the same cycle as s_arvalid, and s_arready follows m_arready combinationally.
